// File: rtl/cpu6_pipereg_stage_pkg.sv
// Shared encodings for the cpu6 pipeline-stage register: state codes and stall counter size.
package cpu6_pipereg_stage_pkg;

  typedef enum logic [1:0] {
    CPU6_PIPE_EMPTY = 2'd0,
    CPU6_PIPE_BUSY  = 2'd1,
    CPU6_PIPE_FULL  = 2'd2
  } pipe_state_e;

  localparam int unsigned CPU6_PIPE_STALLCNT_SIZE = 16;

endpackage

// File: rtl/cpu6_pipereg_stage_dffre.sv
// Resettable flop with load enable; the building block for every register in the stage.
module cpu6_dffre #(
  parameter int unsigned W = 1
) (
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  input  logic         en,
  input  logic         clk,
  input  logic         reset
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/cpu6_pipereg_stage.sv
// Generic cpu6 pipeline-stage register: valid/ready handshake, optional skid entry,
// flush-to-bubble and a saturating stall counter.
module cpu6_pipereg_stage
  import cpu6_pipereg_stage_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SKID        = 1,
  parameter int unsigned ZERO_BUBBLE = 1,
  parameter int unsigned CNTW        = CPU6_PIPE_STALLCNT_SIZE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNTW-1:0]  stall_cnt,
  input  logic             stall_cnt_clr
);

  logic [1:0]       r_state_bits;
  pipe_state_e      w_state;
  pipe_state_e      w_state_d;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] w_main_d;
  logic             w_main_en;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_skid_d;
  logic             w_skid_en;
  logic [CNTW-1:0]  r_cnt;
  logic [CNTW-1:0]  w_cnt_d;
  logic             w_cnt_en;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_stall;

  // State lives in a plain dffre (always enabled) so every register shares one reset flop type.
  assign w_state    = pipe_state_e'(r_state_bits);
  assign out_valid  = (w_state != CPU6_PIPE_EMPTY);
  assign in_ready   = (SKID != 0) ? (w_state != CPU6_PIPE_FULL) : (~out_valid | out_ready);
  assign w_in_fire  = in_valid & in_ready & ~flush;
  assign w_out_fire = out_valid & out_ready;
  assign occupancy  = r_state_bits;
  assign out_data   = (ZERO_BUBBLE != 0) ? (r_main & {WIDTH{out_valid}}) : r_main;

  always_comb begin
    w_state_d = w_state;
    w_main_d  = in_data;
    w_main_en = 1'b0;
    w_skid_d  = in_data;
    w_skid_en = 1'b0;
    if (flush) begin
      w_state_d = CPU6_PIPE_EMPTY;
      w_main_d  = '0;
      w_main_en = 1'b1;
      w_skid_d  = '0;
      w_skid_en = 1'b1;
    end else begin
      case (w_state)
        CPU6_PIPE_EMPTY: begin
          if (w_in_fire) begin
            w_state_d = CPU6_PIPE_BUSY;
            w_main_en = 1'b1;
          end
        end
        CPU6_PIPE_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_main_en = 1'b1;
          end else if (w_in_fire && (SKID != 0)) begin
            w_state_d = CPU6_PIPE_FULL;
            w_skid_en = 1'b1;
          end else if (w_out_fire) begin
            w_state_d = CPU6_PIPE_EMPTY;
          end
        end
        CPU6_PIPE_FULL: begin
          if (w_out_fire) begin
            w_state_d = CPU6_PIPE_BUSY;
            w_main_d  = r_skid;
            w_main_en = 1'b1;
            w_skid_d  = '0;
            w_skid_en = 1'b1;
          end
        end
        default: w_state_d = CPU6_PIPE_EMPTY;
      endcase
    end
  end

  assign w_stall  = out_valid & ~out_ready;
  assign w_cnt_en = stall_cnt_clr | (w_stall & ~(&r_cnt));
  assign w_cnt_d  = stall_cnt_clr ? '0 : (r_cnt + CNTW'(1));
  assign stall_cnt = r_cnt;

  cpu6_dffre #(.W(2)) u_state (
    .d(w_state_d), .q(r_state_bits), .en(1'b1), .clk(clk), .reset(reset)
  );

  cpu6_dffre #(.W(WIDTH)) u_main (
    .d(w_main_d), .q(r_main), .en(w_main_en), .clk(clk), .reset(reset)
  );

  cpu6_dffre #(.W(WIDTH)) u_skid (
    .d(w_skid_d), .q(r_skid), .en(w_skid_en), .clk(clk), .reset(reset)
  );

  cpu6_dffre #(.W(CNTW)) u_cnt (
    .d(w_cnt_d), .q(r_cnt), .en(w_cnt_en), .clk(clk), .reset(reset)
  );

endmodule
